// File: rtl/serial_subtractor_8bit.sv
// serial_subtractor_8bit: bit-serial two's-complement subtractor, diff = a - b - bin.
// One bit per clock, LSB first, through a single full-subtractor cell with a
// registered borrow. Start/busy/done handshake; results update only at completion.
// Optional feature: define SERIAL_SUB_OVERFLOW_EN to add the registered signed
// overflow output ovf.
module serial_subtractor_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             brw_q, brw_d;
    logic             busy_d;
    logic             done_d;
    logic [WIDTH-1:0] diff_d;
    logic             bout_d;

`ifdef SERIAL_SUB_OVERFLOW_EN
    // Operand sign bits kept for the overflow decision at completion.
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_d;
`endif

    // Full-subtractor cell on the current LSBs.
    logic             bit_c;
    logic             brw_nxt_c;
    logic [WIDTH-1:0] res_nxt_c;
    logic             last_c;

    // Single-bit full subtractor and the result shift-in.
    always_comb begin
        bit_c     = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
        brw_nxt_c = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);
        res_nxt_c = {bit_c, res_sh_q[WIDTH-1:1]};
        last_c    = (cnt_q == LAST_BIT);
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        brw_d    = brw_q;
        busy_d   = busy;
        done_d   = 1'b0;
        diff_d   = diff;
        bout_d   = bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    brw_d    = bin;
                    cnt_d    = '0;
                    res_sh_d = '0;
                    busy_d   = 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
`endif
                end
            end

            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                brw_d    = brw_nxt_c;
                res_sh_d = res_nxt_c;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    diff_d  = res_nxt_c;
                    bout_d  = brw_nxt_c;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (bit_c != a_msb_q);
`endif
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            brw_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            brw_q    <= brw_d;
            busy     <= busy_d;
            done     <= done_d;
            diff     <= diff_d;
            bout     <= bout_d;
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    // Captured sign bits and the overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf     <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Bench for serial_subtractor_8bit: arithmetic/timing model plus directed vectors.
module tb_serial_subtractor_8bit;

    localparam int unsigned WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       bin = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic       ovf;
`endif

    serial_subtractor_8bit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: result by plain integer arithmetic, done WIDTH edges after acceptance.
    int         m_left = 0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [7:0] m_diff = 8'h00;
    logic       m_bout = 1'b0;
    logic       m_ovf = 1'b0;
    logic [7:0] p_diff = 8'h00;
    logic       p_bout = 1'b0;
    logic       p_ovf = 1'b0;
    int         full;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_diff = 8'h00;
            m_bout = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left != 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_diff = p_diff;
                    m_bout = p_bout;
                    m_ovf  = p_ovf;
                end
            end else if (start) begin
                full   = int'(a) - int'(b) - int'(bin);
                p_diff = 8'(full);
                p_bout = (full < 0);
                p_ovf  = (a[7] != b[7]) && (p_diff[7] != a[7]);
                m_left = int'(WIDTH);
                m_busy = 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        #2;
        forever begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("diff", 32'(diff), 32'(m_diff));
            chk("bout", 32'(bout), 32'(m_bout));
`ifdef SERIAL_SUB_OVERFLOW_EN
            chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
        end
    end

    task automatic launch(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
        @(negedge clk);
        a     = ia;
        b     = ib;
        bin   = ibin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy, output int at_cyc);
        nbusy  = 0;
        at_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) begin
                at_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (at_cyc < 0) begin
            errors++;
            $display("FAIL done_timeout: no done within 40 cycles at %0t", $time);
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] ia, input logic [7:0] ib,
                          input logic ibin, input logic [7:0] ediff, input logic ebout);
        int nb;
        int t;
        launch(ia, ib, ibin);
        wait_done(nb, t);
        chk({name, "_diff"}, 32'(diff), 32'(ediff));
        chk({name, "_bout"}, 32'(bout), 32'(ebout));
        chk({name, "_busycycles"}, 32'(nb), 32'd8);
    endtask

    initial begin
        int nb;
        int t1;
        int t2;

        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        rst = 1'b0;

        // Basic and boundary vectors.
        run_op("t1", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0);
        run_op("t2a", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        run_op("t2b", 8'h05, 8'h05, 1'b1, 8'hFF, 1'b1);
        run_op("zero_bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        run_op("ff_ff_bin", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_op("ff_00", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);
        run_op("00_ff_bin", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
        run_op("aa_55", 8'hAA, 8'h55, 1'b0, 8'h55, 1'b0);

`ifdef SERIAL_SUB_OVERFLOW_EN
        run_op("ovf1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
        chk("ovf1_ovf", 32'(ovf), 32'd1);
        run_op("ovf0", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
        chk("ovf0_ovf", 32'(ovf), 32'd0);
`endif

        // Start while busy is ignored.
        launch(8'd9, 8'd4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a     = 8'd200;
        b     = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nb, t1);
        chk("ign_diff", 32'(diff), 32'd5);
        chk("ign_bout", 32'(bout), 32'd0);

        // Reset in cycle 4 of an operation clears everything at once.
        launch(8'd77, 8'd3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        chk("mid_rst_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 8'd20, 8'd3, 1'b0, 8'd17, 1'b0);

        // Back-to-back with start held high.
        @(negedge clk);
        a     = 8'd50;
        b     = 8'd8;
        bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        wait_done(nb, t1);
        chk("b2b1_diff", 32'(diff), 32'd42);
        chk("b2b1_bout", 32'(bout), 32'd0);
        a = 8'd7;
        b = 8'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(nb, t2);
        chk("b2b2_diff", 32'(diff), 32'hFE);
        chk("b2b2_bout", 32'(bout), 32'd1);
        chk("b2b_spacing", 32'(t2 - t1), 32'd9);

        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
